// File: rtl/tdc_stat_acc.sv
// -----------------------------------------------------------------------------
// tdc_stat_acc
//
// Window statistics accumulator for the TDC result stream. Collects windows of
// 2^LOG2_N accepted time words and publishes the truncated mean, the minimum
// and the maximum of each window through a valid/ready result port.
//
// Optional build macro: TDC_STAT_OUTLIER_EN
//   When defined, the TDC no-hit / overflow codes (20'h00000, 20'hFFFFF) are
//   rejected while running: they do not enter the window and bump rej_cnt.
//   When undefined, every sample is accepted and rej_cnt stays 0.
//
// Ports:
//   pll_clk    clock, rising edge
//   rst        asynchronous reset, active low
//   en         run enable; low aborts the current window
//   in_time    TDC time word
//   in_dval    in_time valid, single-cycle strobe
//   res_avg    window mean (sum >> LOG2_N)
//   res_min    window minimum (unsigned)
//   res_max    window maximum (unsigned)
//   res_valid  result available
//   res_ready  consumer accepts result
//   ovr        sticky overrun: a result was overwritten before transfer
//   rej_cnt    saturating count of rejected samples
// -----------------------------------------------------------------------------
module tdc_stat_acc #(
    parameter int unsigned LOG2_N = 4,
    parameter int unsigned REJ_W  = 8
) (
    input  logic             pll_clk,
    input  logic             rst,
    input  logic             en,
    input  logic [19:0]      in_time,
    input  logic             in_dval,
    output logic [19:0]      res_avg,
    output logic [19:0]      res_min,
    output logic [19:0]      res_max,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             ovr,
    output logic [REJ_W-1:0] rej_cnt
);

    // Accumulator carries LOG2_N guard bits, so a full window cannot overflow.
    localparam int unsigned AccW = 20 + LOG2_N;

    localparam logic [LOG2_N-1:0] CntOne  = LOG2_N'(1);
    localparam logic [LOG2_N-1:0] CntLast = {LOG2_N{1'b1}};
    localparam logic [REJ_W-1:0]  RejOne  = REJ_W'(1);
    localparam logic [REJ_W-1:0]  RejMax  = {REJ_W{1'b1}};

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e state_q, state_d;

    logic [AccW-1:0]   acc_q, acc_d;
    logic [LOG2_N-1:0] cnt_q, cnt_d;
    logic [19:0]       wmin_q, wmin_d;
    logic [19:0]       wmax_q, wmax_d;

    logic [19:0]       res_avg_q, res_avg_d;
    logic [19:0]       res_min_q, res_min_d;
    logic [19:0]       res_max_q, res_max_d;
    logic              res_valid_q, res_valid_d;
    logic              ovr_q, ovr_d;
    logic [REJ_W-1:0]  rej_q, rej_d;

    logic              run;
    logic              is_code;
    logic              take;
    logic              accept;
    logic              reject;
    logic              first;
    logic              close;
    logic              xfer;
    logic [AccW-1:0]   sum;
    logic [19:0]       new_min;
    logic [19:0]       new_max;

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge pll_clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en)  state_d = StRun;
            StRun:   if (!en) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Samples are taken only when already running and still enabled; the
    // IDLE->RUN edge itself ignores in_dval.
    always_comb begin
        run = 1'b0;
        unique case (state_q)
            StIdle:  run = 1'b0;
            StRun:   run = en;
            default: run = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sample classification
    // -------------------------------------------------------------------------
`ifdef TDC_STAT_OUTLIER_EN
    assign is_code = (in_time == 20'h00000) || (in_time == 20'hFFFFF);
`else
    assign is_code = 1'b0;
`endif

    assign take   = run && in_dval;
    assign accept = take && !is_code;
    assign reject = take && is_code;

    assign first = (cnt_q == '0);
    assign close = accept && (cnt_q == CntLast);
    assign xfer  = res_valid_q && res_ready;

    // Window values including the current sample; a first sample simply seeds
    // the window, whatever stale values the registers hold.
    always_comb begin
        if (first) begin
            sum     = AccW'(in_time);
            new_min = in_time;
            new_max = in_time;
        end else begin
            sum     = acc_q + AccW'(in_time);
            new_min = (in_time < wmin_q) ? in_time : wmin_q;
            new_max = (in_time > wmax_q) ? in_time : wmax_q;
        end
    end

    // -------------------------------------------------------------------------
    // Window registers
    // -------------------------------------------------------------------------
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        wmin_d = wmin_q;
        wmax_d = wmax_q;
        if (!en) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            wmin_d = new_min;
            wmax_d = new_max;
            if (close) begin
                // Restart in the same edge so the next cycle can open a window.
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CntOne;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result register, handshake and overrun
    // -------------------------------------------------------------------------
    always_comb begin
        res_avg_d   = res_avg_q;
        res_min_d   = res_min_q;
        res_max_d   = res_max_q;
        res_valid_d = res_valid_q;
        ovr_d       = ovr_q;

        if (xfer) begin
            res_valid_d = 1'b0;
        end

        if (close) begin
            res_avg_d   = sum[LOG2_N +: 20];
            res_min_d   = new_min;
            res_max_d   = new_max;
            res_valid_d = 1'b1;
            // Overwriting an untransferred result is an overrun; a close that
            // coincides with a transfer is not.
            if (res_valid_q && !res_ready) begin
                ovr_d = 1'b1;
            end
        end

        if (!en) begin
            ovr_d = 1'b0;
        end
    end

    always_comb begin
        rej_d = rej_q;
        if (!en) begin
            rej_d = '0;
        end else if (reject && (rej_q != RejMax)) begin
            rej_d = rej_q + RejOne;
        end
    end

    always_ff @(posedge pll_clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            wmin_q      <= '0;
            wmax_q      <= '0;
            res_avg_q   <= '0;
            res_min_q   <= '0;
            res_max_q   <= '0;
            res_valid_q <= 1'b0;
            ovr_q       <= 1'b0;
            rej_q       <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            wmin_q      <= wmin_d;
            wmax_q      <= wmax_d;
            res_avg_q   <= res_avg_d;
            res_min_q   <= res_min_d;
            res_max_q   <= res_max_d;
            res_valid_q <= res_valid_d;
            ovr_q       <= ovr_d;
            rej_q       <= rej_d;
        end
    end

    assign res_avg   = res_avg_q;
    assign res_min   = res_min_q;
    assign res_max   = res_max_q;
    assign res_valid = res_valid_q;
    assign ovr       = ovr_q;
    assign rej_cnt   = rej_q;

endmodule

// File: doc/tdc_stat_acc.md
Name: tdc_stat_acc

Overview:
- Downstream consumer of the TDC result stream. Takes each 20-bit time word with its 1-cycle valid strobe from the TDC multiplier output.
- Accumulates windows of 2^LOG2_N samples and produces mean, minimum and maximum per window.
- Results leave through a valid/ready handshake to the readout/host interface logic.
- Runs entirely in the pll_clk domain, the same domain as the TDC output stage.

Parameters:
- LOG2_N, 4: window size exponent; window = 2^LOG2_N accepted samples (legal 1..8).
- REJ_W, 8: width of the saturating reject counter.

Ports:
- pll_clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low aborts the current window.
- in_time  in  20  TDC time word.
- in_dval  in  1  in_time valid, single-cycle strobe.
- res_avg  out  20  window mean, truncated.
- res_min  out  20  window minimum.
- res_max  out  20  window maximum.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- ovr  out  1  sticky overrun flag.
- rej_cnt  out  REJ_W  rejected-sample count; saturating.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE.
  - Accumulator, sample counter, res_avg, res_min, res_max, res_valid, ovr and rej_cnt all go to 0.
- FSM states IDLE and RUN:
  - IDLE -> RUN on the first edge with en=1.
  - RUN -> IDLE on any edge with en=0.
  - in_dval is ignored in IDLE.
- Window registers:
  - acc is 20+LOG2_N bits wide, so it cannot overflow.
  - cnt is LOG2_N bits; wmin and wmax are 20 bits each.
  - The first accepted sample of a window loads wmin=wmax=in_time and acc=in_time.
  - Each later accepted sample adds to acc and updates wmin/wmax by unsigned compare.
- Window close:
  - An accepted sample with cnt = 2^LOG2_N-1 closes the window, and that last sample is included.
  - On the next edge: res_avg = (acc+in_time) >> LOG2_N, res_min and res_max take the final values including that sample, and res_valid=1.
  - Latency: result visible in the cycle after the closing in_dval.
  - Window registers restart in the same edge, so a sample in the very next cycle starts the new window with no dead cycle.
- Handshake:
  - Transfer happens on an edge where res_valid=1 and res_ready=1; res_valid clears on that edge unless a new window closes on it.
  - res_* stay stable while res_valid=1 and res_ready=0.
  - res_ready while res_valid=0 has no effect.
- Overrun:
  - If a window closes while res_valid=1 and res_ready=0, the new result overwrites the old one, res_valid stays 1 and ovr is set.
  - A close on the same edge as a transfer loads the new result with res_valid=1 and does not set ovr.
- en=0 mid-window:
  - Partial window is discarded: cnt and acc are cleared, and ovr and rej_cnt are cleared.
  - A pending result (res_valid=1) is kept until it is transferred.
  - Samples with en=0 are dropped.
- rej_cnt stays 0 without the optional feature.

Optional Feature:
- Macro TDC_STAT_OUTLIER_EN.
- Defined:
  - A sample with in_time == 20'h00000 or in_time == 20'hFFFFF (TDC no-hit/overflow codes) is rejected while in RUN.
  - A rejected sample does not touch acc, cnt, wmin or wmax, and increments rej_cnt, saturating at all-ones.
  - A window therefore still needs 2^LOG2_N good samples to close.
- Not defined:
  - Every sample is accepted and rej_cnt is tied to 0.
- The port list is identical in both builds.

Test Plan:
1. LOG2_N=2, en=1, samples 100,200,300,400 -> one cycle after 4th dval: res_avg=250, res_min=100, res_max=400, res_valid=1; holds with res_ready=0; clears on the edge after res_ready=1.
2. Samples 1,1,1,2 -> res_avg=1 (5>>2, truncation), min=1, max=2; samples 4×20'hFFFFE -> res_avg=20'hFFFFE, no wrap.
3. res_ready=0 held across two windows (10,10,10,10 then 20,20,20,20) -> res_avg=20, ovr=1, res_valid=1. Then en=0 -> ovr=0, result still presented until transferred.
4. Window closes on the same edge res_ready=1 accepts the previous result -> new result loaded, res_valid stays 1, ovr=0. Back-to-back dval with no gaps across a window boundary -> no sample lost; 8 samples give 2 results.
5. en dropped after samples 7,9 (2 samples), then raised with samples 1,2,3,6 -> res_avg=3, min=1, max=6. Async rst pulse mid-window -> all outputs 0 immediately.
6. With TDC_STAT_OUTLIER_EN: samples 0,100,20'hFFFFF,100,100,100 -> rej_cnt=2, one result res_avg=100. Without the macro, the same stimulus closes the window after 0,100,FFFFF,100 with res_avg=(0+100+1048575+100)>>2=262193 and rej_cnt=0.
